// File: rtl/cdtime_pkg.sv
// Shared constants and types for the countdown-time keypad.
// Key codes, countdown limit and the debounce state encoding.
package cdtime_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_ENTER  = 4'd11;
  localparam logic [4:0] CDTIME_MAX = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } deb_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM for the scanned keypad.
// Optional KEYPAD_AUTOREPEAT_EN re-pulses held digit keys.
module keypad_debounce
  import cdtime_pkg::*;
#(
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_stb,
  input  logic       i_frame_none,
  input  logic [3:0] i_frame_key,
  output logic       o_key_valid,
  output logic [3:0] o_key_code
);

  deb_state_t r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_key;
  logic [7:0] w_cnt_inc;
  logic       w_cnt_done;

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_cnt_done = (w_cnt_inc >= 8'(DEB_FRAMES));

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [5:0] r_rep;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_key       <= 4'd0;
      o_key_valid <= 1'b0;
      o_key_code  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep       <= 6'd0;
`endif
    end else begin
      o_key_valid <= 1'b0;
      if (i_frame_stb) begin
        unique case (r_state)
          ST_IDLE: begin
            if (!i_frame_none) begin
              r_state <= ST_DEBOUNCE;
              r_cnt   <= 8'd1;
              r_key   <= i_frame_key;
            end
          end
          ST_DEBOUNCE: begin
            if (!i_frame_none && i_frame_key == r_key) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_done) begin
                o_key_valid <= 1'b1;
                o_key_code  <= r_key;
                r_state     <= ST_HELD;
                r_cnt       <= 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                r_rep       <= 6'd0;
`endif
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= 8'd0;
            end
          end
          ST_HELD: begin
            if (i_frame_none) begin
              r_state <= ST_RELEASE;
              r_cnt   <= 8'd1;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              // 32 frames to first repeat, then one every 8
              if (i_frame_key == r_key && r_key < KEY_CLEAR) begin
                if (r_rep == 6'd31) begin
                  o_key_valid <= 1'b1;
                  o_key_code  <= r_key;
                  r_rep       <= 6'd24;
                end else begin
                  r_rep <= r_rep + 6'd1;
                end
              end
`else
              r_state <= ST_HELD;
`endif
            end
          end
          ST_RELEASE: begin
            if (i_frame_none) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_done) begin
                r_state <= ST_IDLE;
                r_cnt   <= 8'd0;
              end
            end else begin
              r_state <= ST_HELD;
              r_cnt   <= 8'd0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdtime_keypad.sv
// 4x4 keypad scanner and countdown-time entry.
// Define KEYPAD_AUTOREPEAT_EN for held-digit auto-repeat.
module cdtime_keypad
  import cdtime_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEB_FRAMES     = 4,
  parameter int DEFAULT_CDTIME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw7,
  input  logic [1:0] game_state,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [4:0] user_defined_cdtime
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          r_run;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [1:0]    r_hits;
  logic [3:0]    r_key;
  logic          r_frame_stb;
  logic          r_frame_none;
  logic [3:0]    r_frame_key;
  logic [6:0]    r_pending;
  logic [4:0]    r_cdtime;

  logic       w_last;
  logic [3:0] w_low;
  logic [2:0] w_pop;
  logic [2:0] w_tot;
  logic [1:0] w_row;
  logic       w_entry;
  logic [6:0] w_digit;

  assign w_last = r_run && (r_div == DW'(SCAN_DIV - 1));
  assign w_low  = ~key_row;
  assign w_pop  = {2'b0, w_low[0]} + {2'b0, w_low[1]}
                + {2'b0, w_low[2]} + {2'b0, w_low[3]};
  assign w_tot  = {1'b0, r_hits} + w_pop;

  always_comb begin
    w_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_low[i]) w_row = 2'(i);
    end
  end

  assign key_col = r_run ? ~(4'b0001 << r_col) : 4'b1111;

  // Crossings accumulate over the frame; hits saturate at 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run        <= 1'b0;
      r_div        <= '0;
      r_col        <= 2'd0;
      r_hits       <= 2'd0;
      r_key        <= 4'd0;
      r_frame_stb  <= 1'b0;
      r_frame_none <= 1'b1;
      r_frame_key  <= 4'd0;
    end else begin
      r_run       <= 1'b1;
      r_frame_stb <= 1'b0;
      if (r_run) begin
        if (w_last) begin
          r_div <= '0;
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_frame_stb  <= 1'b1;
            r_frame_none <= (w_tot != 3'd1);
            r_frame_key  <= (w_pop == 3'd1) ? {r_col, w_row} : r_key;
            r_hits       <= 2'd0;
            r_key        <= 4'd0;
          end else begin
            r_hits <= (w_tot > 3'd1) ? 2'd2 : w_tot[1:0];
            if (w_pop == 3'd1) r_key <= {r_col, w_row};
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  keypad_debounce #(
    .DEB_FRAMES (DEB_FRAMES)
  ) u_deb (
    .clk          (clk),
    .rst          (rst),
    .i_frame_stb  (r_frame_stb),
    .i_frame_none (r_frame_none),
    .i_frame_key  (r_frame_key),
    .o_key_valid  (key_valid),
    .o_key_code   (key_code)
  );

  assign w_entry = sw7 && (game_state == 2'd0);
  assign w_digit = (r_pending % 7'd10) * 7'd10 + {3'b000, key_code};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 7'd0;
      r_cdtime  <= 5'(DEFAULT_CDTIME);
    end else if (!w_entry) begin
      r_pending <= 7'd0;
    end else if (key_valid) begin
      unique case (1'b1)
        (key_code < KEY_CLEAR): r_pending <= w_digit;
        (key_code == KEY_CLEAR): r_pending <= 7'd0;
        (key_code == KEY_ENTER): begin
          r_pending <= 7'd0;
          if (r_pending > {2'b00, CDTIME_MAX}) r_cdtime <= CDTIME_MAX;
          else if (r_pending != 7'd0) r_cdtime <= r_pending[4:0];
        end
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign user_defined_cdtime = r_cdtime;

endmodule

// File: tb/tb_cdtime_keypad.sv
// Directed bench for cdtime_keypad with SCAN_DIV=4, DEB_FRAMES=2.
// A keypad model drives rows from the column drive and a pressed-key mask.
module tb_cdtime_keypad;

  localparam int FR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw7 = 1'b1;
  logic [1:0] game_state = 2'd0;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic [4:0] user_defined_cdtime;

  logic [15:0] pressed = 16'h0000;
  int checks = 0;
  int failures = 0;
  int n_pulses = 0;

  cdtime_keypad #(
    .SCAN_DIV       (4),
    .DEB_FRAMES     (2),
    .DEFAULT_CDTIME (10)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sw7                 (sw7),
    .game_state          (game_state),
    .key_row             (key_row),
    .key_col             (key_col),
    .key_valid           (key_valid),
    .key_code            (key_code),
    .user_defined_cdtime (user_defined_cdtime)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) n_pulses++;

  task automatic press_key(input int k, input int nf);
    @(negedge clk);
    pressed = 16'h0001 << k;
    repeat (nf*FR) @(negedge clk);
    pressed = 16'h0000;
    repeat (4*FR) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    int p0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (key_col !== 4'b1111) begin
      failures++; $display("FAIL rst_col got=%b exp=1111", key_col);
    end
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'd0) begin
      failures++; $display("FAIL rst_key got=%b/%0d exp=0/0", key_valid, key_code);
    end
    checks++;
    if (user_defined_cdtime !== 5'd10) begin
      failures++; $display("FAIL rst_cdtime got=%0d exp=10", user_defined_cdtime);
    end
    p0 = n_pulses;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = ~(4'b0001 << (i/4));
      checks++;
      if (key_col !== exp) begin
        failures++; $display("FAIL scan_col[%0d] got=%b exp=%b", i, key_col, exp);
      end
    end
    repeat (2*FR) @(negedge clk);
    checks++;
    if (n_pulses != p0) begin
      failures++; $display("FAIL idle_pulses got=%0d exp=0", n_pulses - p0);
    end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = n_pulses;
    press_key(3, 1);
    checks++;
    if (n_pulses != p0) begin
      failures++; $display("FAIL bounce_pulses got=%0d exp=0", n_pulses - p0);
    end
  endtask

  task automatic test_single;
    int p0;
    p0 = n_pulses;
    press_key(3, 2);
    checks++;
    if (n_pulses != p0 + 1) begin
      failures++; $display("FAIL single_pulses got=%0d exp=1", n_pulses - p0);
    end
    checks++;
    if (key_code !== 4'd3) begin
      failures++; $display("FAIL single_code got=%0d exp=3", key_code);
    end
  endtask

  task automatic test_entry;
    int p0;
    press_key(10, 3);
    p0 = n_pulses;
    press_key(2, 3);
    press_key(5, 3);
    press_key(11, 3);
    checks++;
    if (n_pulses != p0 + 3) begin
      failures++; $display("FAIL entry_pulses got=%0d exp=3", n_pulses - p0);
    end
    checks++;
    if (user_defined_cdtime !== 5'd25) begin
      failures++; $display("FAIL entry_25 got=%0d exp=25", user_defined_cdtime);
    end
    checks++;
    if (key_code !== 4'd11) begin
      failures++; $display("FAIL entry_code got=%0d exp=11", key_code);
    end
  endtask

  task automatic test_clamp;
    press_key(4, 3);
    press_key(5, 3);
    press_key(11, 3);
    checks++;
    if (user_defined_cdtime !== 5'd30) begin
      failures++; $display("FAIL clamp_45 got=%0d exp=30", user_defined_cdtime);
    end
    press_key(0, 3);
    press_key(11, 3);
    checks++;
    if (user_defined_cdtime !== 5'd30) begin
      failures++; $display("FAIL zero_enter got=%0d exp=30", user_defined_cdtime);
    end
  endtask

  task automatic test_digits;
    press_key(1, 3);
    press_key(2, 3);
    press_key(3, 3);
    press_key(11, 3);
    checks++;
    if (user_defined_cdtime !== 5'd23) begin
      failures++; $display("FAIL last_two got=%0d exp=23", user_defined_cdtime);
    end
    press_key(9, 3);
    press_key(10, 3);
    press_key(7, 3);
    press_key(11, 3);
    checks++;
    if (user_defined_cdtime !== 5'd7) begin
      failures++; $display("FAIL clear got=%0d exp=7", user_defined_cdtime);
    end
  endtask

  task automatic test_latency;
    bit found;
    press_key(1, 3);
    press_key(2, 3);
    found = 1'b0;
    @(negedge clk);
    pressed = 16'h0001 << 11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL lat_timeout got=none exp=pulse");
    end else begin
      if (user_defined_cdtime !== 5'd7) begin
        failures++; $display("FAIL lat_early got=%0d exp=7", user_defined_cdtime);
      end
      @(negedge clk);
      checks++;
      if (user_defined_cdtime !== 5'd12) begin
        failures++; $display("FAIL lat_next got=%0d exp=12", user_defined_cdtime);
      end
    end
    repeat (FR) @(negedge clk);
    pressed = 16'h0000;
    repeat (4*FR) @(negedge clk);
  endtask

  task automatic test_hold;
    int p0;
    p0 = n_pulses;
    press_key(8, 50);
    checks++;
    if (n_pulses != p0 + 1) begin
      failures++; $display("FAIL hold50_pulses got=%0d exp=1", n_pulses - p0);
    end
  endtask

  task automatic test_two_keys;
    int p0;
    p0 = n_pulses;
    @(negedge clk);
    pressed = 16'h0042;
    repeat (4*FR) @(negedge clk);
    pressed = 16'h0000;
    repeat (4*FR) @(negedge clk);
    checks++;
    if (n_pulses != p0) begin
      failures++; $display("FAIL two_keys got=%0d exp=0", n_pulses - p0);
    end
  endtask

  task automatic test_gamestate;
    int p0;
    game_state = 2'd1;
    p0 = n_pulses;
    press_key(7, 3);
    press_key(11, 3);
    checks++;
    if (n_pulses != p0 + 2) begin
      failures++; $display("FAIL gs_pulses got=%0d exp=2", n_pulses - p0);
    end
    checks++;
    if (user_defined_cdtime !== 5'd12) begin
      failures++; $display("FAIL gs_hold got=%0d exp=12", user_defined_cdtime);
    end
    game_state = 2'd0;
    press_key(11, 3);
    checks++;
    if (user_defined_cdtime !== 5'd12) begin
      failures++; $display("FAIL pend_clr got=%0d exp=12", user_defined_cdtime);
    end
  endtask

  task automatic test_rst_mid;
    int p0;
    bit sync;
    sync = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (key_col === 4'b0111) begin
        sync = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 16 && sync; i++) begin
      @(negedge clk);
      if (key_col === 4'b1110) break;
    end
    checks++;
    if (!sync || key_col !== 4'b1110) begin
      failures++; $display("FAIL mid_sync got=%b exp=1110", key_col);
    end
    p0 = n_pulses;
    pressed = 16'h0001 << 2;
    repeat (23) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (key_col !== 4'b1111) begin
      failures++; $display("FAIL mid_col got=%b exp=1111", key_col);
    end
    checks++;
    if (user_defined_cdtime !== 5'd10) begin
      failures++; $display("FAIL mid_cdtime got=%0d exp=10", user_defined_cdtime);
    end
    pressed = 16'h0000;
    rst = 1'b0;
    repeat (4*FR) @(negedge clk);
    checks++;
    if (n_pulses != p0) begin
      failures++; $display("FAIL mid_pulses got=%0d exp=0", n_pulses - p0);
    end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_single;
    test_entry;
    test_clamp;
    test_digits;
    test_latency;
    test_hold;
    test_two_keys;
    test_gamestate;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
